mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide (signed and unsigned), one result bit per cycle.
// Signed operations run on magnitudes; result signs are fixed up in a dedicated FIX state.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d, rneg_q, rneg_d, done_q, done_d, dz_q, dz_d;

    logic               sgn;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic [WIDTH:0]     msum, shifted, trial;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        sgn      = ~op[0];
        a_mag    = (sgn && a[WIDTH-1]) ? -a : a;
        b_mag    = (sgn && b[WIDTH-1]) ? -b : b;
        msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        trial    = shifted - {1'b0, b_q};
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    div_d  = op[1];
                    a_d    = a_mag;
                    b_d    = b_mag;
                    neg_d  = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                    rneg_d = sgn && a[WIDTH-1];
                    dz_d   = op[1] && (b == '0);
                    cnt_d  = '0;
                    // Multiplier (or dividend) sits in the low half and is consumed one bit per cycle
                    acc_d  = {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
                    if (op[1] && (b == '0)) begin
                        hi_d    = a;
                        lo_d    = '1;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
                CALC: begin
                    acc_d = !div_q ? {msum, acc_q[WIDTH-1:1]} :
                            !trial[WIDTH] ? {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1} :
                                            {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH-1)) begin
                        cnt_d   = '0;
                        state_d = FIX;
                    end
                end
                FIX: begin
                    hi_d    = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                    lo_d    = div_q ? quo_fix : prod_fix[WIDTH-1:0];
                    state_d = DONE;
                end
                default: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = state_q != IDLE;
    assign done     = done_q;
    assign div_zero = dz_q;
endmodule
